// File: rtl/rf_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// rf_writeback_arbiter
//
// Purpose:
//   Shares the single register-file write port between NREQ writeback
//   requesters (e.g. ALU, load unit, CSR unit). A round-robin arbiter picks
//   one valid requester per cycle. The winning write goes through a
//   one-cycle registered write stage. A per-register busy scoreboard is
//   set by issue logic and cleared when the write reaches the register
//   file. The scoreboard feeds the hazard-query outputs.
//
// Parameters:
//   NREQ  number of writeback requesters (2..8)
//   XLEN  register data width
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_valid     per-requester pending writeback
//   req_ready     one-hot grant; a transfer is req_valid[i] && req_ready[i]
//   req_rd        5-bit destination per requester, slice i = [5i+4:5i]
//   req_data      XLEN-bit data per requester, slice i = [XLEN*i +: XLEN]
//   rf_we/rf_rd/rf_rd_data  registered register-file write port
//   issue_valid/issue_rd    reserve a destination (sets its busy bit)
//   rs1/rs2       hazard query indices
//   rs1_busy/rs2_busy       busy[rsN]; x0 is never busy
//   idle          no busy bits set and no write in flight
// ---------------------------------------------------------------------------
module rf_writeback_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [XLEN-1:0]      rf_rd_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 idle
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PW-1:0]   r_ptr;      // round-robin search start
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic [31:0]     r_busy;     // bit 0 is held at zero

  // -------------------------------------------------------------------------
  // Requester slices as unpacked arrays so the winner can be muxed by index
  // -------------------------------------------------------------------------
  logic [4:0]      w_rd_arr   [NREQ];
  logic [XLEN-1:0] w_data_arr [NREQ];
  logic [PW-1:0]   w_cand     [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [PW:0] w_sum;

      assign w_rd_arr[gi]   = req_rd[5*gi +: 5];
      assign w_data_arr[gi] = req_data[XLEN*gi +: XLEN];

      // Candidate at search position gi is (ptr + gi) mod NREQ. Both terms
      // are below NREQ, so a single conditional subtract is enough.
      assign w_sum        = {1'b0, r_ptr} + (PW+1)'(gi);
      assign w_cand[gi]   = (w_sum >= (PW+1)'(NREQ)) ?
                            PW'(w_sum - (PW+1)'(NREQ)) : w_sum[PW-1:0];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin arbitration: first valid requester at or after r_ptr
  // -------------------------------------------------------------------------
  logic          w_any;
  logic [PW-1:0] w_win;

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[w_cand[k]]) begin
        w_any = 1'b1;
        w_win = w_cand[k];
      end
    end
  end

  // Grant is one-hot on the winner and never looks at the scoreboard, so a
  // requester can always drain even if its destination is still reserved.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_any && (w_win == PW'(gi));
    end
  endgenerate

  logic [4:0]      w_win_rd;
  logic [XLEN-1:0] w_win_data;
  logic [PW-1:0]   w_ptr_next;

  assign w_win_rd   = w_rd_arr[w_win];
  assign w_win_data = w_data_arr[w_win];
  assign w_ptr_next = (w_win == PW'(NREQ-1)) ? '0 : w_win + PW'(1);

  // -------------------------------------------------------------------------
  // Registered write stage and pointer. A transfer always completes, even
  // to x0; it simply does not raise the write enable.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_we   <= 1'b0;
      r_rd   <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_any && (w_win_rd != 5'd0);
      if (w_any) begin
        r_ptr  <= w_ptr_next;
        r_rd   <= w_win_rd;
        r_data <= w_win_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Busy scoreboard. A set and a clear of the same register on one edge
  // resolve to set: the new reservation belongs to a younger instruction
  // than the write that is completing.
  // -------------------------------------------------------------------------
  logic [31:0] w_busy_next;

  generate
    for (gi = 0; gi < 32; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic w_set;
        logic w_clr;
        assign w_set           = issue_valid && (issue_rd == 5'(gi));
        assign w_clr           = r_we && (r_rd == 5'(gi));
        assign w_busy_next[gi] = w_set | (r_busy[gi] & ~w_clr);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Queries read the registered scoreboard only, so an issue or a
  // clear in the current cycle is not visible until after the edge.
  // -------------------------------------------------------------------------
  assign rf_we      = r_we;
  assign rf_rd      = r_rd;
  assign rf_rd_data = r_data;

  assign rs1_busy = (rs1 != 5'd0) && r_busy[rs1];
  assign rs2_busy = (rs2 != 5'd0) && r_busy[rs2];
  assign idle     = ~(|r_busy) && !r_we;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_rd = '0;
  logic [XLEN*NREQ-1:0] req_data = '0;
  logic                 rf_we;
  logic [4:0]           rf_rd;
  logic [XLEN-1:0]      rf_rd_data;
  logic                 issue_valid = 1'b0;
  logic [4:0]           issue_rd = '0;
  logic [4:0]           rs1 = '0;
  logic [4:0]           rs2 = '0;
  logic                 rs1_busy, rs2_busy, idle;

  rf_writeback_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .idle(idle)
  );

  // Requesters: each holds its request until it is consumed.
  bit          pv   [NREQ];
  logic [4:0]  prd  [NREQ];
  logic [31:0] pdat [NREQ];

  // Behavioural model of the visible state.
  int          m_ptr;
  bit          m_busy [32];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (pv[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NREQ; i++) if (pv[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]            = pv[i];
      req_rd[5*i +: 5]        = prd[i];
      req_data[XLEN*i +: XLEN] = pdat[i];
    end
  endtask

  task automatic model_compare();
    int w;
    logic [NREQ-1:0] e_ready;
    bit any_busy;
    if (!m_valid) return;
    w = winner();
    e_ready = '0;
    if (w >= 0) e_ready[w] = 1'b1;
    any_busy = 1'b0;
    for (int r = 0; r < 32; r++) if (m_busy[r]) any_busy = 1'b1;
    chk("m_req_ready",  64'(req_ready),  64'(e_ready));
    chk("m_rf_we",      64'(rf_we),      64'(m_we));
    chk("m_rf_rd",      64'(rf_rd),      64'(m_rd));
    chk("m_rf_rd_data", 64'(rf_rd_data), 64'(m_data));
    chk("m_rs1_busy",   64'(rs1_busy),   64'((rs1 != 0) && m_busy[rs1]));
    chk("m_rs2_busy",   64'(rs2_busy),   64'((rs2 != 0) && m_busy[rs2]));
    chk("m_idle",       64'(idle),       64'(!any_busy && !m_we));
  endtask

  task automatic model_update();
    int w;
    if (rst) begin
      m_ptr = 0;
      for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      m_we = 1'b0; m_rd = '0; m_data = '0;
      m_valid = 1'b1;
      return;
    end
    w = winner();
    if (m_we) m_busy[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (w >= 0) begin
      $display("xfer req=%0d rd=%0d data=%08h t=%0t", w, prd[w], pdat[w], $time);
      m_we   = (prd[w] != 0);
      m_rd   = prd[w];
      m_data = pdat[w];
      m_ptr  = (w + 1) % NREQ;
      pv[w]  = 1'b0;
    end else begin
      m_we = 1'b0;
    end
  endtask

  task automatic settle();
    apply();
    @(negedge clk);
    model_compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (any_pending() && guard < 20) begin
      settle(); advance(); guard++;
    end
    chk("drain_bound", 64'(any_pending()), 64'(0));
  endtask

  logic [NREQ-1:0] exp_g  [4];
  logic [4:0]      exp_rd [4];

  initial begin
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    exp_rd[0] = 5'd1;  exp_rd[1] = 5'd2;  exp_rd[2] = 5'd3;  exp_rd[3] = 5'd1;
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = 1'b1; prd[i] = 5'(i + 1); pdat[i] = 32'h1000_0000 + i;
    end

    // Reset for two cycles with all requesters valid.
    rst = 1'b1;
    settle(); advance();
    settle();
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_rs1_busy", 64'(rs1_busy), 64'(0));
    chk("rst_rs2_busy", 64'(rs2_busy), 64'(0));
    chk("rst_ready_ptr0", 64'(req_ready), 64'(3'b001));
    advance();
    rst = 1'b0;

    // Round robin with all three requesters continuously valid.
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NREQ; i++) pv[i] = 1'b1;
      settle();
      if (c < 4) chk("rr_grant", 64'(req_ready), 64'(exp_g[c]));
      if (c >= 1) begin
        chk("rr_we", 64'(rf_we), 64'(1));
        chk("rr_rd", 64'(rf_rd), 64'(exp_rd[c-1]));
      end
      advance();
    end
    drain();

    // Single write with one-cycle latency.
    pv[1] = 1'b1; prd[1] = 5'd5; pdat[1] = 32'hDEADBEEF;
    settle();
    chk("single_ready", 64'(req_ready), 64'(3'b010));
    advance();
    settle();
    chk("single_we", 64'(rf_we), 64'(1));
    chk("single_rd", 64'(rf_rd), 64'(5));
    chk("single_data", 64'(rf_rd_data), 64'(32'hDEADBEEF));
    advance();

    // Scoreboard set then clear by write to x7.
    issue_valid = 1'b1; issue_rd = 5'd7;
    settle(); advance();
    issue_valid = 1'b0; rs1 = 5'd7;
    settle();
    chk("sb_busy_after_issue", 64'(rs1_busy), 64'(1));
    advance();
    pv[0] = 1'b1; prd[0] = 5'd7; pdat[0] = 32'hAAAA5555;
    settle(); advance();
    settle();
    chk("sb_we7", 64'(rf_we), 64'(1));
    chk("sb_rd7", 64'(rf_rd), 64'(7));
    chk("sb_busy_during_write", 64'(rs1_busy), 64'(1));
    advance();
    settle();
    chk("sb_busy_cleared", 64'(rs1_busy), 64'(0));
    advance();

    // Set/clear collision on x9: set wins.
    issue_valid = 1'b1; issue_rd = 5'd9;
    settle(); advance();
    issue_valid = 1'b0;
    pv[2] = 1'b1; prd[2] = 5'd9; pdat[2] = 32'h0000_0909;
    settle(); advance();
    issue_valid = 1'b1; issue_rd = 5'd9; rs2 = 5'd9;
    settle();
    chk("col_we", 64'(rf_we), 64'(1));
    chk("col_rd", 64'(rf_rd), 64'(9));
    advance();
    issue_valid = 1'b0;
    settle();
    chk("col_busy_kept", 64'(rs2_busy), 64'(1));
    advance();

    // x0: accepted, never written, never busy.
    pv[2] = 1'b1; prd[2] = 5'd0; pdat[2] = 32'h0000_1234;
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    settle();
    chk("x0_ready", 64'(req_ready), 64'(3'b100));
    advance();
    issue_valid = 1'b0;
    settle();
    chk("x0_we", 64'(rf_we), 64'(0));
    chk("x0_data", 64'(rf_rd_data), 64'(32'h1234));
    chk("x0_busy", 64'(rs1_busy), 64'(0));
    advance();

    // Reset while a write is in flight.
    pv[0] = 1'b1; prd[0] = 5'd12; pdat[0] = 32'hCAFE0012;
    issue_valid = 1'b1; issue_rd = 5'd12;
    settle(); advance();
    issue_valid = 1'b0; rst = 1'b1;
    settle();
    chk("rstw_we_before", 64'(rf_we), 64'(1));
    advance();
    rst = 1'b0; rs1 = 5'd12; rs2 = 5'd9;
    settle();
    chk("rstw_we_after", 64'(rf_we), 64'(0));
    chk("rstw_rs1", 64'(rs1_busy), 64'(0));
    chk("rstw_rs2", 64'(rs2_busy), 64'(0));
    chk("rstw_idle", 64'(idle), 64'(1));
    advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1'b1;
          prd[i] = 5'($urandom_range(0, 15));
          pdat[i] = $urandom;
        end
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom_range(0, 15));
      rs1         = 5'($urandom_range(0, 15));
      rs2         = 5'($urandom_range(0, 15));
      rst         = ($urandom_range(0, 199) == 0);
      settle(); advance();
    end
    rst = 1'b0; issue_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
